row_pack_writer: RTL
====================

ROW_PACK_WRITER -- requirements
Module: row_pack_writer

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning pixels per row.
REQ-002 SHALL have parameter IMG_H, default 480, meaning rows per frame.
REQ-003 SHALL have parameter PIX_W, default 8, meaning bits per pixel; row word width is IMG_W*PIX_W (5120 at defaults).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin capturing a frame.
REQ-007 SHALL have port pix_valid  input  1  upstream pixel valid.
REQ-008 SHALL have port pix_data  input  PIX_W  upstream pixel value.
REQ-009 SHALL have port pix_ready  output  1  block accepts a pixel this cycle.
REQ-010 SHALL have port mem_we  output  1  row-buffer write enable.
REQ-011 SHALL have port mem_addr  output  9  row-buffer row address, 0..IMG_H-1.
REQ-012 SHALL have port mem_din  output  IMG_W*PIX_W  packed row word.
REQ-013 SHALL have port busy  output  1  frame capture in progress.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last row is written.

Function
REQ-015 SHALL implement states IDLE, FILL, WRITE, DONE; all outputs registered or decoded from state only.
REQ-016 In IDLE, start=1 SHALL move to FILL with row counter=0 and column counter=0; start in any other state SHALL be ignored.
REQ-017 pix_ready SHALL be 1 only in FILL; a pixel is accepted on a cycle where pix_valid=1 and pix_ready=1.
REQ-018 On each acceptance, the row register SHALL shift right by PIX_W with pix_data entering the top PIX_W bits, so column c ends in bits [c*PIX_W+PIX_W-1 : c*PIX_W].
REQ-019 The column counter SHALL increment per acceptance; the acceptance of column IMG_W-1 SHALL move to WRITE and clear the column counter.
REQ-020 mem_we SHALL be 1 for exactly the one cycle spent in WRITE, the cycle after the last pixel of the row is accepted; mem_din holds the complete row and mem_addr holds the current row index during it.
REQ-021 mem_din SHALL equal the row register at all times; mem_addr SHALL equal the row counter at all times.
REQ-022 From WRITE: if row counter < IMG_H-1, increment it and return to FILL; if row counter = IMG_H-1, go to DONE.
REQ-023 DONE SHALL last one cycle with frame_done=1, then go to IDLE with row counter=0.
REQ-024 busy SHALL be 1 in FILL, WRITE, DONE and 0 in IDLE.
REQ-025 pix_valid=0 in FILL SHALL stall without changing counters or the row register; pixels offered outside FILL SHALL not be consumed.
REQ-026 Per-frame throughput SHALL be IMG_W*IMG_H acceptances plus one stall cycle per row; no pixel SHALL be dropped or duplicated.
REQ-027 The row register SHALL not be cleared between rows; each row fully overwrites it.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, counters 0, row register 0, pix_ready=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, frame_done=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no further mem_we; after release, the block waits for a new start.

Verification
REQ-030 Reset then start, 640 pixels with value = column mod 256, pix_valid always 1 -> pix_ready low exactly one cycle after pixel 639; mem_we=1 one cycle, mem_addr=0, mem_din[7:0]=0x00, mem_din[15:8]=0x01, mem_din[5119:5112]=0x7F.
REQ-031 Full frame of 480 rows, continuous valid -> exactly 480 mem_we pulses with addresses 0..479 in order, frame_done one cycle after the write to 479, then busy=0 and pix_ready=0.
REQ-032 Random pix_valid gaps (50%) over 3 rows -> mem_din contents identical to the gap-free case; mem_we count = 3.
REQ-033 start pulsed during FILL of row 5 -> no restart; row counter continues, row 5 written at mem_addr=5.
REQ-034 rst_n asserted after 300 pixels of row 10 -> all outputs 0 asynchronously; no mem_we afterwards until a new start and 640 further pixels, which are written at mem_addr=0.
REQ-035 pix_valid=1 held in IDLE before start -> no acceptance, no mem_we; first accepted pixel is the one presented in the cycle after start.

Source files
------------

// File: rtl/row_pack_writer.sv
// Packs a stream of pixels into full-row words and writes one word per row
// into a row buffer, sequencing a whole frame per start request.
module row_pack_writer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   pix_valid,
  input  logic [PIX_W-1:0]       pix_data,
  output logic                   pix_ready,
  output logic                   mem_we,
  output logic [8:0]             mem_addr,
  output logic [IMG_W*PIX_W-1:0] mem_din,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int ROW_W = IMG_W * PIX_W;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [COL_W-1:0]   r_col;
  logic [COL_W-1:0]   w_col_next;
  logic [8:0]         r_row;
  logic [8:0]         w_row_next;
  logic [ROW_W-1:0]   r_row_data;
  logic               w_accept;
  logic               w_last_col;
  logic               w_last_row;

  assign w_accept   = (r_state == S_FILL) && pix_valid;
  assign w_last_col = (r_col == COL_W'(IMG_W - 1));
  assign w_last_row = (r_row == 9'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_FILL;
          w_col_next   = '0;
          w_row_next   = '0;
        end
      end
      S_FILL: begin
        if (w_accept) begin
          if (w_last_col) begin
            w_state_next = S_WRITE;
            w_col_next   = '0;
          end else begin
            w_col_next = r_col + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (w_last_row) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_FILL;
          w_row_next   = r_row + 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_row_next   = '0;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Shift right so the first pixel of the row lands in the lowest bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_data <= '0;
    end else if (w_accept) begin
      r_row_data <= {pix_data, r_row_data[ROW_W-1:PIX_W]};
    end
  end

  assign pix_ready  = (r_state == S_FILL);
  assign mem_we     = (r_state == S_WRITE);
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign mem_addr   = r_row;
  assign mem_din    = r_row_data;

endmodule
